uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

UART receive controller for the serial link. It detects the start bit on the asynchronous `rxd` line and requests bit timing from `speed_slect` by holding `bps_start`. It samples each bit on the mid-bit `clk_bps` tick that `speed_slect` returns, and delivers a parallel byte with a one-cycle valid strobe plus error flags. It sits directly upstream of `speed_slect` on the control path (drives `bps_start`) and downstream of it on the timing path (consumes `clk_bps`).

## Interface
Parameters:
- `DATA_BITS`, 8, data bits per frame, LSB first.
- `SYNC_STAGES`, 2, flip-flops in the `rxd` synchronizer (minimum 2).

Ports:
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  reset; one clock, reset is asynchronous and active-low.
- `rxd`  in  1  serial input, idle high, asynchronous to `clk`.
- `clk_bps`  in  1  single-cycle mid-bit tick from `speed_slect`.
- `bps_start`  out  1  high for the whole frame; enables the `speed_slect` counter.
- `rx_data`  out  DATA_BITS  last good byte; holds until next good frame.
- `rx_valid`  out  1  one-cycle pulse, `rx_data` updated this cycle.
- `frame_err`  out  1  one-cycle pulse, stop bit sampled low.
- `parity_err`  out  1  one-cycle pulse, parity mismatch (constant 0 without macro).
- `rx_busy`  out  1  high whenever state is not IDLE.

## Operation
- `rxd` passes through a SYNC_STAGES synchronizer, then a 1-cycle delay register. A falling edge is synced-previous=1 and synced-current=0.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP. All transitions except IDLE->START occur only on a cycle with `clk_bps`=1.
- IDLE: falling edge -> START; `bps_start` goes 1 on the next clock edge. A `clk_bps` tick seen in IDLE is ignored.
- START, on tick: synced `rxd`=0 -> DATA with bit counter cleared. Synced `rxd`=1 -> false start: go to IDLE, drop `bps_start`, no pulses.
- DATA, on tick: shift the sampled bit into the MSB of the shift register, right-shifting, so bit 0 arrives first. After DATA_BITS ticks go to PARITY (macro) or STOP. The counter is $clog2(DATA_BITS+1) bits wide and wraps only via the clear in START.
- PARITY, on tick: latch the parity bit -> STOP.
- STOP, on tick, go to IDLE and drop `bps_start`:
  - Synced `rxd`=1: load `rx_data` and pulse `rx_valid`. With the macro, also pulse `parity_err` on mismatch; data is still delivered.
  - Synced `rxd`=0: pulse `frame_err`; no `rx_valid`, `rx_data` unchanged, no `parity_err`.
- Falling edges outside IDLE are ignored.
- After a frame error with the line held low (break), IDLE re-arms only after `rxd` returns high and falls again.
- Reset mid-frame: FSM to IDLE, all outputs to reset values immediately. The partial frame is discarded.

## Timing
- Reset values: `bps_start`=0, `rx_data`=0, `rx_valid`=0, `frame_err`=0, `parity_err`=0, `rx_busy`=0. Synchronizer and delay registers reset to 1 (idle line).
- Edge-detect latency: SYNC_STAGES+1 clocks from the `rxd` fall to the START transition; `bps_start` is registered in the same cycle.
- Each tick-driven transition takes effect on the clock edge that samples `clk_bps`=1.
- `rx_valid`, `frame_err` and `parity_err` assert for exactly one cycle, the cycle after the STOP tick. `bps_start` is 0 in that same cycle.
- The earliest next START is one cycle after returning to IDLE. This leaves half a stop bit of margin for back-to-back frames.

## Configuration
- `UART_RX_PARITY_EN` defined: one even-parity bit follows the data, and the PARITY state exists. `parity_err` pulses when XOR(data, parity bit)=1.
- Not defined: no PARITY state, frame is start + DATA_BITS + stop, and `parity_err` is tied 0.

## Structure
- Shared package `uart_pkg`: the FSM state enum and the baud divisor constants (9600 through 115200, full and half values) shared with `speed_slect`.
- One sub-module, `rx_sync_edge`: synchronizer plus falling-edge detector, with outputs `rxd_s` and `rxd_fall`.

## Test plan
Bench instantiates `speed_slect` with BPS_PARA=15 and BPS_PARA_2=7 (16-clock bits).
- Send 0x55, stop=1 -> `rx_data`=0x55, single `rx_valid` pulse, `bps_start` low the same cycle, `rx_busy` low afterwards.
- Send 0xA3 then 0x0F back-to-back with one stop bit -> two `rx_valid` pulses carrying 0xA3 then 0x0F, no errors.
- `rxd` low for 3 clocks, then high -> false start: returns to IDLE at the first tick, `bps_start` drops, no pulses.
- Send 0x3C with stop=0 -> `frame_err` pulse, no `rx_valid`, `rx_data` keeps the prior 0x0F. Hold the line low, then release and send 0x81 -> 0x81 received.
- Assert `rst_n`=0 during data bit 4 of 0xFF -> all outputs 0 at once. After release, send 0x12 -> 0x12 received.
- With `UART_RX_PARITY_EN`: send 0x07 with parity=0 -> `rx_valid` plus `parity_err`, `rx_data`=0x07. Send 0x07 with parity=1 -> `rx_valid` only.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and 50 MHz baud divisors used with speed_slect.
// The PARITY state is reachable only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int unsigned CLK_HZ = 50_000_000;

  // Full divisor is clocks per bit; the _2 value marks the mid-bit sampling point.
  localparam int unsigned BPS_9600     = 5208;
  localparam int unsigned BPS_9600_2   = 2604;
  localparam int unsigned BPS_19200    = 2604;
  localparam int unsigned BPS_19200_2  = 1302;
  localparam int unsigned BPS_38400    = 1302;
  localparam int unsigned BPS_38400_2  = 651;
  localparam int unsigned BPS_57600    = 868;
  localparam int unsigned BPS_57600_2  = 434;
  localparam int unsigned BPS_115200   = 434;
  localparam int unsigned BPS_115200_2 = 217;

endpackage

// File: rtl/uart_rx_ctrl_sync.sv
// rx_sync_edge: multi-flop synchronizer for rxd plus a falling-edge detector.
// Independent of UART_RX_PARITY_EN.
module rx_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rxd,
  output logic rxd_s,
  output logic rxd_fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  // Reset to ones so an idle-high line does not look like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      dly_q  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rxd_s    = sync_q[SYNC_STAGES-1];
  assign rxd_fall = dly_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detect, mid-bit sampling on clk_bps, byte delivery with error flags.
// Define UART_RX_PARITY_EN to add an even-parity bit and the PARITY state.
module uart_rx_ctrl #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  input  logic                 clk_bps,
  output logic                 bps_start,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 rx_busy
);
  import uart_pkg::*;

  localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  logic rxd_s;
  logic rxd_fall;

  rx_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .rxd     (rxd),
    .rxd_s   (rxd_s),
    .rxd_fall(rxd_fall)
  );

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 bps_q, bps_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (rxd_fall) state_d = START;
      end
      START: begin
        if (clk_bps) begin
          if (!rxd_s) begin
            state_d = DATA;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (clk_bps) begin
          shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (clk_bps) begin
          par_d   = rxd_s;
          state_d = STOP;
        end
`else
        state_d = IDLE;
`endif
      end
      STOP: begin
        if (clk_bps) begin
          state_d = IDLE;
          if (rxd_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_d  = (^shift_q) ^ par_q;
`endif
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    bps_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      bps_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      bps_q   <= bps_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign bps_start = bps_q;
  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign rx_busy   = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a 16-clock-per-bit tick generator (full 15, half 7).
// Parity steps are compiled in when UART_RX_PARITY_EN is defined.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       clk_bps;
  logic       bps_start;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       rx_busy;

  int checks = 0;
  int failures = 0;

  int valid_cnt = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  int overlap_cnt = 0;
  logic [7:0] rx_log[$];

  logic [3:0] bps_cnt;

  uart_rx_ctrl #(
    .DATA_BITS(8),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .clk_bps   (clk_bps),
    .bps_start (bps_start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .rx_busy   (rx_busy)
  );

  always #10 clk = ~clk;

  // Behavioural stand-in for speed_slect: mid-bit tick at count 7 of a 0..15 cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bps_cnt <= 4'd0;
    else if (!bps_start || bps_cnt == 4'd15) bps_cnt <= 4'd0;
    else bps_cnt <= bps_cnt + 4'd1;
  end
  assign clk_bps = bps_start && (bps_cnt == 4'd7);

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        valid_cnt++;
        rx_log.push_back(rx_data);
        if (bps_start) overlap_cnt++;
      end
      if (frame_err) ferr_cnt++;
      if (parity_err) perr_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    @(posedge clk);
    #1 rxd = b;
    repeat (15) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`else
    if (par === 1'bx) $display("note: parity value unused");
`endif
    drive_bit(stop);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_bps_start", bps_start, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_parity_err", parity_err, 0);
    check("rst_rx_busy", rx_busy, 0);
    rst_n = 1'b1;
    idle(5);

    // Single frame 0x55
    send_frame(8'h55, 1'b0, 1'b1);
    idle(4);
    #1;
    check("f55_valid_cnt", valid_cnt, 1);
    check("f55_log", rx_log[0], 8'h55);
    check("f55_rx_data", rx_data, 8'h55);
    check("f55_bps_overlap", overlap_cnt, 0);
    check("f55_busy_after", rx_busy, 0);
    check("f55_bps_after", bps_start, 0);

    // Back-to-back 0xA3, 0x0F
    send_frame(8'hA3, 1'b0, 1'b1);
    send_frame(8'h0F, 1'b0, 1'b1);
    idle(4);
    check("b2b_valid_cnt", valid_cnt, 3);
    check("b2b_first", rx_log[1], 8'hA3);
    check("b2b_second", rx_log[2], 8'h0F);
    check("b2b_ferr", ferr_cnt, 0);

    // False start: 3 clocks low; also checks edge-detect latency
    @(posedge clk);
    #1 rxd = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 check("fs_bps_before_latency", bps_start, 0);
    @(posedge clk);
    #1 check("fs_bps_at_latency", bps_start, 1);
    check("fs_busy", rx_busy, 1);
    rxd = 1'b1;
    idle(30);
    #1;
    check("fs_bps_dropped", bps_start, 0);
    check("fs_busy_dropped", rx_busy, 0);
    check("fs_valid_cnt", valid_cnt, 3);
    check("fs_ferr_cnt", ferr_cnt, 0);

    // Frame error 0x3C with stop=0, then break held low
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(4);
    check("fe_ferr_cnt", ferr_cnt, 1);
    check("fe_valid_cnt", valid_cnt, 3);
    check("fe_rx_data", rx_data, 8'h0F);
    idle(40);
    #1;
    check("brk_busy", rx_busy, 0);
    check("brk_bps", bps_start, 0);
    rxd = 1'b1;
    idle(32);
    send_frame(8'h81, 1'b0, 1'b1);
    idle(4);
    check("brk_valid_cnt", valid_cnt, 4);
    check("brk_log", rx_log[3], 8'h81);

    // Reset during data bit 4 of 0xFF
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    @(posedge clk);
    #1 rxd = 1'b1;
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mrst_bps", bps_start, 0);
    check("mrst_rx_data", rx_data, 0);
    check("mrst_valid", rx_valid, 0);
    check("mrst_busy", rx_busy, 0);
    check("mrst_ferr", frame_err, 0);
    idle(3);
    #1 rst_n = 1'b1;
    idle(32);
    check("mrst_no_valid", valid_cnt, 4);
    send_frame(8'h12, 1'b0, 1'b1);
    idle(4);
    check("mrst_valid_cnt", valid_cnt, 5);
    check("mrst_log", rx_log[4], 8'h12);
    check("mrst_rx_data_after", rx_data, 8'h12);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b0, 1'b1);
    idle(4);
    check("par_bad_valid_cnt", valid_cnt, 6);
    check("par_bad_perr_cnt", perr_cnt, 1);
    check("par_bad_data", rx_log[5], 8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    idle(4);
    check("par_good_valid_cnt", valid_cnt, 7);
    check("par_good_perr_cnt", perr_cnt, 1);
`else
    check("nopar_perr_cnt", perr_cnt, 0);
`endif
    check("final_overlap", overlap_cnt, 0);
    check("final_ferr", ferr_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
